// File: rtl/id_hazard_pipe.sv
// ID-stage register with forwarding scoreboard, load-use bubble insertion and flush.
// Optional performance counters are compiled in when ID_HAZARD_PERF_EN is defined.
module id_hazard_pipe #(
  parameter int RF_AW     = 5,
  parameter int PAYLOAD_W = 96,
  parameter int FWD_DEPTH = 2,
  parameter int SEL_W     = $clog2(FWD_DEPTH + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 if2id_valid,
  output logic                 if2id_ready,
  input  logic                 dec_reg_wen,
  input  logic [RF_AW-1:0]     dec_reg_waddr,
  input  logic [RF_AW-1:0]     dec_rs1_addr,
  input  logic [RF_AW-1:0]     dec_rs2_addr,
  input  logic                 dec_rs1_used,
  input  logic                 dec_rs2_used,
  input  logic                 dec_is_load,
  input  logic                 dec_ill_instr,
  input  logic [PAYLOAD_W-1:0] dec_payload,
  input  logic                 flush,
  input  logic                 id2ex_ready,
  output logic                 id2ex_valid,
  output logic                 id2ex_reg_wen,
  output logic [RF_AW-1:0]     id2ex_reg_waddr,
  output logic                 id2ex_is_load,
  output logic                 id2ex_ill_instr,
  output logic [PAYLOAD_W-1:0] id2ex_payload,
  output logic [SEL_W-1:0]     id2ex_rs1_fwd_sel,
  output logic [SEL_W-1:0]     id2ex_rs2_fwd_sel
`ifdef ID_HAZARD_PERF_EN
  ,
  output logic [31:0]          perf_stall_cnt,
  output logic [31:0]          perf_bubble_cnt,
  output logic [31:0]          perf_flush_cnt
`endif
);

  localparam int SB_N = (FWD_DEPTH > 1) ? FWD_DEPTH - 1 : 1;

  function automatic logic src_hit(input logic             ent_v,
                                   input logic [RF_AW-1:0] ent_a,
                                   input logic [RF_AW-1:0] rs,
                                   input logic             used);
    return ent_v & used & (rs != '0) & (rs == ent_a);
  endfunction

  // Youngest (lowest index) matching entry wins.
  function automatic logic [SEL_W-1:0] pick_sel(input logic hits [FWD_DEPTH]);
    logic [SEL_W-1:0] sel;
    sel = '0;
    for (int k = FWD_DEPTH - 1; k >= 0; k--) begin
      if (hits[k]) sel = SEL_W'(k + 1);
    end
    return sel;
  endfunction

  logic                 valid_q, valid_d;
  logic                 wen_q, wen_d;
  logic [RF_AW-1:0]     waddr_q, waddr_d;
  logic                 is_load_q, is_load_d;
  logic                 ill_q, ill_d;
  logic [PAYLOAD_W-1:0] payload_q, payload_d;
  logic [SEL_W-1:0]     sel1_q, sel1_d;
  logic [SEL_W-1:0]     sel2_q, sel2_d;

  logic                 sb_wen_q  [SB_N];
  logic                 sb_wen_d  [SB_N];
  logic [RF_AW-1:0]     sb_addr_q [SB_N];
  logic [RF_AW-1:0]     sb_addr_d [SB_N];

  logic                 ent_v  [FWD_DEPTH];
  logic [RF_AW-1:0]     ent_a  [FWD_DEPTH];
  logic                 rs1_hit [FWD_DEPTH];
  logic                 rs2_hit [FWD_DEPTH];

  logic advance;
  logic e0_load_match;
  logic stall;
  logic valid_in;

  // Entry 0 is the id2ex register; deeper entries come from the shift register.
  always_comb begin
    ent_v[0] = valid_q & wen_q;
    ent_a[0] = waddr_q;
    for (int k = 1; k < FWD_DEPTH; k++) begin
      ent_v[k] = sb_wen_q[k-1];
      ent_a[k] = sb_addr_q[k-1];
    end
    for (int k = 0; k < FWD_DEPTH; k++) begin
      rs1_hit[k] = src_hit(ent_v[k], ent_a[k], dec_rs1_addr, dec_rs1_used);
      rs2_hit[k] = src_hit(ent_v[k], ent_a[k], dec_rs2_addr, dec_rs2_used);
    end
  end

  assign advance       = id2ex_ready | ~valid_q;
  assign e0_load_match = is_load_q & (rs1_hit[0] | rs2_hit[0]);
  assign stall         = if2id_valid & e0_load_match;
  assign valid_in      = if2id_valid & ~stall;
  assign if2id_ready   = advance & ~stall & ~flush;

  always_comb begin
    valid_d   = valid_q;
    wen_d     = wen_q;
    waddr_d   = waddr_q;
    is_load_d = is_load_q;
    ill_d     = ill_q;
    payload_d = payload_q;
    sel1_d    = sel1_q;
    sel2_d    = sel2_q;
    if (flush) begin
      valid_d   = 1'b0;
      wen_d     = 1'b0;
      is_load_d = 1'b0;
      ill_d     = 1'b0;
    end else if (advance) begin
      valid_d   = valid_in;
      wen_d     = dec_reg_wen & ~dec_ill_instr & valid_in;
      waddr_d   = dec_reg_waddr;
      is_load_d = dec_is_load & ~dec_ill_instr;
      ill_d     = dec_ill_instr & valid_in;
      payload_d = dec_payload;
      sel1_d    = pick_sel(rs1_hit);
      sel2_d    = pick_sel(rs2_hit);
    end
  end

  // A flushed id2ex instruction enters the scoreboard as a non-writer.
  always_comb begin
    for (int j = 0; j < SB_N; j++) begin
      sb_wen_d[j]  = sb_wen_q[j];
      sb_addr_d[j] = sb_addr_q[j];
    end
    if (id2ex_ready) begin
      sb_wen_d[0]  = valid_q & wen_q & ~flush;
      sb_addr_d[0] = waddr_q;
      for (int j = 1; j < SB_N; j++) begin
        sb_wen_d[j]  = sb_wen_q[j-1];
        sb_addr_d[j] = sb_addr_q[j-1];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q   <= 1'b0;
      wen_q     <= 1'b0;
      waddr_q   <= '0;
      is_load_q <= 1'b0;
      ill_q     <= 1'b0;
      payload_q <= '0;
      sel1_q    <= '0;
      sel2_q    <= '0;
      for (int j = 0; j < SB_N; j++) begin
        sb_wen_q[j]  <= 1'b0;
        sb_addr_q[j] <= '0;
      end
    end else begin
      valid_q   <= valid_d;
      wen_q     <= wen_d;
      waddr_q   <= waddr_d;
      is_load_q <= is_load_d;
      ill_q     <= ill_d;
      payload_q <= payload_d;
      sel1_q    <= sel1_d;
      sel2_q    <= sel2_d;
      for (int j = 0; j < SB_N; j++) begin
        sb_wen_q[j]  <= sb_wen_d[j];
        sb_addr_q[j] <= sb_addr_d[j];
      end
    end
  end

  assign id2ex_valid       = valid_q;
  assign id2ex_reg_wen     = wen_q;
  assign id2ex_reg_waddr   = waddr_q;
  assign id2ex_is_load     = is_load_q;
  assign id2ex_ill_instr   = ill_q;
  assign id2ex_payload     = payload_q;
  assign id2ex_rs1_fwd_sel = sel1_q;
  assign id2ex_rs2_fwd_sel = sel2_q;

`ifdef ID_HAZARD_PERF_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] bubble_cnt_q, bubble_cnt_d;
  logic [31:0] flush_cnt_q, flush_cnt_d;

  always_comb begin
    stall_cnt_d  = stall_cnt_q + {31'd0, stall};
    bubble_cnt_d = bubble_cnt_q + {31'd0, ~valid_q & id2ex_ready};
    flush_cnt_d  = flush_cnt_q + {31'd0, flush};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_q  <= '0;
      bubble_cnt_q <= '0;
      flush_cnt_q  <= '0;
    end else begin
      stall_cnt_q  <= stall_cnt_d;
      bubble_cnt_q <= bubble_cnt_d;
      flush_cnt_q  <= flush_cnt_d;
    end
  end

  assign perf_stall_cnt  = stall_cnt_q;
  assign perf_bubble_cnt = bubble_cnt_q;
  assign perf_flush_cnt  = flush_cnt_q;
`endif

endmodule

// File: tb/tb_id_hazard_pipe.sv
// Directed, table-driven bench for id_hazard_pipe (default build, FWD_DEPTH=2).
module tb_id_hazard_pipe;

  localparam int RF_AW     = 5;
  localparam int PAYLOAD_W = 96;
  localparam int FWD_DEPTH = 2;
  localparam int SEL_W     = 2;
  localparam int NV        = 20;

  logic                 clk;
  logic                 rst;
  logic                 if2id_valid;
  logic                 if2id_ready;
  logic                 dec_reg_wen;
  logic [RF_AW-1:0]     dec_reg_waddr;
  logic [RF_AW-1:0]     dec_rs1_addr;
  logic [RF_AW-1:0]     dec_rs2_addr;
  logic                 dec_rs1_used;
  logic                 dec_rs2_used;
  logic                 dec_is_load;
  logic                 dec_ill_instr;
  logic [PAYLOAD_W-1:0] dec_payload;
  logic                 flush;
  logic                 id2ex_ready;
  logic                 id2ex_valid;
  logic                 id2ex_reg_wen;
  logic [RF_AW-1:0]     id2ex_reg_waddr;
  logic                 id2ex_is_load;
  logic                 id2ex_ill_instr;
  logic [PAYLOAD_W-1:0] id2ex_payload;
  logic [SEL_W-1:0]     id2ex_rs1_fwd_sel;
  logic [SEL_W-1:0]     id2ex_rs2_fwd_sel;

  id_hazard_pipe #(
    .RF_AW(RF_AW), .PAYLOAD_W(PAYLOAD_W), .FWD_DEPTH(FWD_DEPTH), .SEL_W(SEL_W)
  ) dut (
    .clk(clk), .rst(rst),
    .if2id_valid(if2id_valid), .if2id_ready(if2id_ready),
    .dec_reg_wen(dec_reg_wen), .dec_reg_waddr(dec_reg_waddr),
    .dec_rs1_addr(dec_rs1_addr), .dec_rs2_addr(dec_rs2_addr),
    .dec_rs1_used(dec_rs1_used), .dec_rs2_used(dec_rs2_used),
    .dec_is_load(dec_is_load), .dec_ill_instr(dec_ill_instr),
    .dec_payload(dec_payload), .flush(flush), .id2ex_ready(id2ex_ready),
    .id2ex_valid(id2ex_valid), .id2ex_reg_wen(id2ex_reg_wen),
    .id2ex_reg_waddr(id2ex_reg_waddr), .id2ex_is_load(id2ex_is_load),
    .id2ex_ill_instr(id2ex_ill_instr), .id2ex_payload(id2ex_payload),
    .id2ex_rs1_fwd_sel(id2ex_rs1_fwd_sel), .id2ex_rs2_fwd_sel(id2ex_rs2_fwd_sel)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic v, wen;
    logic [4:0] rd, rs1, rs2;
    logic u1, u2, ld, ill;
    logic e_rin;
    logic e_v, e_wen, e_ld, e_ill;
    logic [1:0] e_s1, e_s2;
    logic [4:0] e_rd;
  } vec_t;

  int n_cmp = 0;
  int n_bad = 0;
  vec_t tv [NV];

  function automatic vec_t mk(input int v, wen, rd, rs1, rs2, u1, u2, ld, ill,
                              input int rin, ev, ewen, eld, eill, s1, s2, erd);
    vec_t t;
    t.v = 1'(v); t.wen = 1'(wen); t.rd = 5'(rd); t.rs1 = 5'(rs1); t.rs2 = 5'(rs2);
    t.u1 = 1'(u1); t.u2 = 1'(u2); t.ld = 1'(ld); t.ill = 1'(ill);
    t.e_rin = 1'(rin); t.e_v = 1'(ev); t.e_wen = 1'(ewen); t.e_ld = 1'(eld);
    t.e_ill = 1'(eill); t.e_s1 = 2'(s1); t.e_s2 = 2'(s2); t.e_rd = 5'(erd);
    return t;
  endfunction

  function automatic logic [95:0] pl_of(input int i);
    return {32'(i), 32'hA5A5_0000 + 32'(i), 32'(i * 7)};
  endfunction

  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t t, input logic [95:0] pl, input logic fl, input logic rdy);
    if2id_valid   = t.v;
    dec_reg_wen   = t.wen;
    dec_reg_waddr = t.rd;
    dec_rs1_addr  = t.rs1;
    dec_rs2_addr  = t.rs2;
    dec_rs1_used  = t.u1;
    dec_rs2_used  = t.u2;
    dec_is_load   = t.ld;
    dec_ill_instr = t.ill;
    dec_payload   = pl;
    flush         = fl;
    id2ex_ready   = rdy;
  endtask

  task automatic step(input vec_t t, input logic [95:0] pl, input logic rdy,
                      input logic [95:0] epl, input string tag);
    @(negedge clk);
    drive(t, pl, 1'b0, rdy);
    #1 chk({tag, ".if2id_ready"}, 96'(if2id_ready), 96'(t.e_rin));
    @(posedge clk);
    #1;
    chk({tag, ".valid"},   96'(id2ex_valid),       96'(t.e_v));
    chk({tag, ".wen"},     96'(id2ex_reg_wen),     96'(t.e_wen));
    chk({tag, ".is_load"}, 96'(id2ex_is_load),     96'(t.e_ld));
    chk({tag, ".ill"},     96'(id2ex_ill_instr),   96'(t.e_ill));
    chk({tag, ".waddr"},   96'(id2ex_reg_waddr),   96'(t.e_rd));
    chk({tag, ".rs1_sel"}, 96'(id2ex_rs1_fwd_sel), 96'(t.e_s1));
    chk({tag, ".rs2_sel"}, 96'(id2ex_rs2_fwd_sel), 96'(t.e_s2));
    chk({tag, ".payload"}, id2ex_payload,          epl);
  endtask

  task automatic chk_cleared(input string tag);
    chk({tag, ".valid"},   96'(id2ex_valid),       96'(0));
    chk({tag, ".wen"},     96'(id2ex_reg_wen),     96'(0));
    chk({tag, ".is_load"}, 96'(id2ex_is_load),     96'(0));
    chk({tag, ".ill"},     96'(id2ex_ill_instr),   96'(0));
    chk({tag, ".waddr"},   96'(id2ex_reg_waddr),   96'(0));
    chk({tag, ".rs1_sel"}, 96'(id2ex_rs1_fwd_sel), 96'(0));
    chk({tag, ".rs2_sel"}, 96'(id2ex_rs2_fwd_sel), 96'(0));
    chk({tag, ".payload"}, id2ex_payload,          96'(0));
  endtask

  initial begin
    vec_t h;
    //          v wen rd rs1 rs2 u1 u2 ld ill | rin  v wen ld ill s1 s2 rd
    tv[0]  = mk(1, 1,  5,  1,  0, 1, 0, 0, 0,   1,   1, 1, 0, 0,  0, 0,  5); // addi x5
    tv[1]  = mk(1, 1,  6,  5,  5, 1, 1, 0, 0,   1,   1, 1, 0, 0,  1, 1,  6); // add x6,x5,x5
    tv[2]  = mk(1, 1,  7,  2,  0, 1, 0, 1, 0,   1,   1, 1, 1, 0,  0, 0,  7); // lw x7
    tv[3]  = mk(1, 1,  8,  7,  1, 1, 1, 0, 0,   0,   0, 0, 0, 0,  1, 0,  8); // load-use bubble
    tv[4]  = mk(1, 1,  8,  7,  1, 1, 1, 0, 0,   1,   1, 1, 0, 0,  2, 0,  8); // consumer issues
    tv[5]  = mk(1, 1,  9,  3,  0, 1, 0, 0, 0,   1,   1, 1, 0, 0,  0, 0,  9); // writer x9
    tv[6]  = mk(1, 1, 10,  4, 11, 1, 1, 0, 0,   1,   1, 1, 0, 0,  0, 0, 10); // independent
    tv[7]  = mk(1, 1, 12,  9, 10, 1, 1, 0, 0,   1,   1, 1, 0, 0,  2, 1, 12); // distance 2 and 1
    tv[8]  = mk(1, 1,  0,  1,  0, 1, 0, 0, 0,   1,   1, 1, 0, 0,  0, 0,  0); // write x0
    tv[9]  = mk(1, 1,  0,  0,  0, 1, 0, 1, 0,   1,   1, 1, 1, 0,  0, 0,  0); // lw x0, reads x0
    tv[10] = mk(1, 1, 13,  0,  0, 1, 1, 0, 0,   1,   1, 1, 0, 0,  0, 0, 13); // x0 reader: no stall
    tv[11] = mk(1, 1,  3,  5,  0, 1, 0, 1, 1,   1,   1, 0, 0, 1,  0, 0,  3); // illegal rd=x3
    tv[12] = mk(1, 1, 14,  3,  0, 1, 0, 0, 0,   1,   1, 1, 0, 0,  0, 0, 14); // reader x3
    tv[13] = mk(1, 1, 15,  3, 14, 1, 1, 0, 0,   1,   1, 1, 0, 0,  0, 1, 15); // x3 dist 2, x14 dist 1
    tv[14] = mk(1, 1, 16, 15, 14, 0, 0, 0, 0,   1,   1, 1, 0, 0,  0, 0, 16); // unused sources
    tv[15] = mk(1, 1, 16, 16,  0, 1, 0, 0, 0,   1,   1, 1, 0, 0,  1, 0, 16); // rewrite x16
    tv[16] = mk(1, 1, 17, 16,  0, 1, 0, 0, 0,   1,   1, 1, 0, 0,  1, 0, 17); // youngest wins
    tv[17] = mk(0, 1, 19, 17,  0, 1, 0, 0, 0,   1,   0, 0, 0, 0,  1, 0, 19); // no instruction
    tv[18] = mk(1, 1, 17, 17,  0, 1, 0, 0, 0,   1,   1, 1, 0, 0,  2, 0, 17); // x17 across bubble
    tv[19] = mk(1, 1, 16,  0,  0, 0, 0, 0, 0,   1,   1, 1, 0, 0,  0, 0, 16); // writer x16

    rst = 1'b1;
    drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), '0, 1'b0, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    chk_cleared("reset");
    chk("reset.if2id_ready", 96'(if2id_ready), 96'(1));
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < NV; i++) begin
      step(tv[i], pl_of(i), 1'b1, pl_of(i), $sformatf("tv%0d", i));
    end

    // Downstream stall: x16 writer sits in id2ex, x17 in the scoreboard entry.
    h = mk(1, 1, 18, 16, 17, 1, 1, 0, 0, 0, 1, 1, 0, 0, 0, 0, 16);
    for (int c = 0; c < 3; c++) step(h, pl_of(40), 1'b0, pl_of(19), $sformatf("dstall%0d", c));
    h = mk(1, 1, 18, 16, 17, 1, 1, 0, 0, 1, 1, 1, 0, 0, 1, 2, 18);
    step(h, pl_of(40), 1'b1, pl_of(40), "release");

    // Flush while a load-use stall is pending.
    step(mk(1, 1, 20, 1, 0, 1, 0, 1, 0, 1, 1, 1, 1, 0, 0, 0, 20), pl_of(41), 1'b1, pl_of(41), "lw_x20");
    h = mk(1, 1, 21, 20, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    drive(h, pl_of(42), 1'b0, 1'b1);
    #1 chk("lu_stall.if2id_ready", 96'(if2id_ready), 96'(0));
    flush = 1'b1;
    #1 chk("flush.if2id_ready", 96'(if2id_ready), 96'(0));
    @(posedge clk);
    #1;
    chk("flush.valid", 96'(id2ex_valid), 96'(0));
    chk("flush.wen", 96'(id2ex_reg_wen), 96'(0));
    step(mk(1, 1, 21, 20, 0, 1, 0, 0, 0, 1, 1, 1, 0, 0, 0, 0, 21), pl_of(42), 1'b1, pl_of(42), "post_flush");

    // Asynchronous reset takes effect before the next clock edge.
    @(negedge clk);
    drive(tv[1], pl_of(43), 1'b0, 1'b1);
    rst = 1'b1;
    #1;
    chk_cleared("async_rst");
    chk("async_rst.if2id_ready", 96'(if2id_ready), 96'(1));
    @(negedge clk);
    rst = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/id_hazard_pipe.md
Name: id_hazard_pipe

Overview:
- Parametrised successor ID-stage pipeline/hazard block.
- Sits between IF/ID and EX. Registers decoded fields into the id2ex stage with a valid/ready handshake.
- Tracks in-flight writers over FWD_DEPTH downstream stages and produces per-source forwarding selects.
- Detects load-use hazards and inserts bubbles; honours pipeline flush.

Parameters:
- RF_AW, 5, register-file address width.
- PAYLOAD_W, 96, width of opaque decoded bundle (rs data, imm, alu op, mem ops).
- FWD_DEPTH, 2, number of forwardable downstream stages (EX-out, MEM-out, ...); minimum 1.
- SEL_W, $clog2(FWD_DEPTH+1), forward-select width.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- if2id_valid  in  1  decoded instruction present
- if2id_ready  out  1  block accepts the instruction this cycle
- dec_reg_wen  in  1  instruction writes rd
- dec_reg_waddr  in  RF_AW  rd
- dec_rs1_addr / dec_rs2_addr  in  RF_AW  sources
- dec_rs1_used / dec_rs2_used  in  1  source actually read
- dec_is_load  in  1  instruction is a load
- dec_ill_instr  in  1  illegal instruction
- dec_payload  in  PAYLOAD_W  decoded bundle
- flush  in  1  kill ID and EX contents
- id2ex_ready  in  1  downstream advances
- id2ex_valid  out  1  stage register valid
- id2ex_reg_wen  out  1  qualified rd write enable
- id2ex_reg_waddr  out  RF_AW  rd
- id2ex_is_load  out  1  qualified load flag
- id2ex_ill_instr  out  1  illegal flag
- id2ex_payload  out  PAYLOAD_W  registered bundle
- id2ex_rs1_fwd_sel / id2ex_rs2_fwd_sel  out  SEL_W  0 = regfile, k = stage k (1 = youngest)

Behaviour:
- Reset (async assert, synchronous release): every output register is 0. That includes valid, wen, ill, is_load, payload and both selects. All scoreboard entries are cleared. if2id_ready follows combinationally from the cleared state.
- advance = id2ex_ready | ~id2ex_valid.
- stall = if2id_valid & entry0-load-match, where entry0-load-match = id2ex_valid & id2ex_is_load & id2ex_reg_wen & for some rsN: rsN_used & rsN==id2ex_reg_waddr & rsN!=0.
- if2id_ready = advance & ~stall & ~flush. Combinational; no dependence on if2id_valid except through stall.
- On advance (flush=0):
  - id2ex_valid <= if2id_valid & ~stall.
  - Fields load from dec_* regardless of valid.
  - id2ex_reg_wen <= dec_reg_wen & ~dec_ill_instr & valid-in.
  - id2ex_is_load <= dec_is_load & ~dec_ill_instr.
- On ~advance, all stage registers hold.
- Stall inserts exactly one bubble per load-use. Next cycle the load has moved to entry1, so the consumer issues with sel=2.
- Flush: top priority. Next edge id2ex_valid=0 and id2ex_reg_wen=0; the incoming instruction is dropped (if2id_ready=0). Entries 1..FWD_DEPTH-1 are retained.
- Scoreboard:
  - entry0 is the id2ex register itself. Entries 1..FWD_DEPTH-1 hold {wen, waddr}.
  - On id2ex_ready: entry[k] <= entry[k-1] and entry1 <= {id2ex_valid & id2ex_reg_wen & ~flush, id2ex_reg_waddr}.
  - When id2ex_ready=0, entries hold.
- Forward select, computed combinationally from the next-issue instruction and registered on advance: lowest k (youngest) whose entry is valid & wen & waddr==rsN & rsN!=0 & rsN_used gives sel=k+1; otherwise sel=0.
- x0 never forwarded; x0 never triggers stall.
- Illegal instruction: passes with valid=1, ill=1, wen=0, is_load=0. It never creates a hazard.
- Simultaneous WB write of the same register as an older entry: the youngest match wins. The regfile bypass is not relied upon for depth ≤ FWD_DEPTH.

Optional Feature:
- Macro ID_HAZARD_PERF_EN.
- When defined: adds outputs perf_stall_cnt (32), perf_bubble_cnt (32) and perf_flush_cnt (32).
  - perf_stall_cnt increments each cycle stall=1.
  - perf_bubble_cnt increments each cycle id2ex_valid=0 & id2ex_ready=1.
  - perf_flush_cnt increments on flush.
  - All three wrap at 2^32 and reset to 0.
- When undefined: ports and logic are absent; remaining behaviour is identical.

Test Plan:
- Back-to-back dependency: addi x5 then add x6,x5,x5, id2ex_ready=1 -> second issues next cycle, rs1_sel=rs2_sel=1, no stall.
- Load-use: lw x7 then add x8,x7,x1 -> one cycle if2id_ready=0 with bubble (id2ex_valid=0); consumer then issues with rs1_sel=2, rs2_sel=0.
- Distance-2 and x0: writer x9, independent op, reader x9 -> rs1_sel=2. A reader of x0 after a write to x0 -> sel=0, no stall.
- Downstream stall: id2ex_ready=0 for 3 cycles with id2ex_valid=1 -> stage and scoreboard hold, if2id_ready=0. Release -> selects unchanged and correct.
- Flush during load-use stall: flush=1 -> next cycle id2ex_valid=0, no hazard from the killed load, and a following reader gets sel=0.
- Illegal opcode with rd=x3, then reader of x3 -> id2ex_ill_instr=1, wen=0; the reader gets sel=0.
